// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode/funct3 constants, ROB tag width default and ALU result record.
package riscv_pkg;
  localparam int ROB_IDX_W_DEF = 5;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } alu_res_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I integer datapath; redirect resolution only when ALU_BRANCH_EN is defined.
module alu_core
  import riscv_pkg::*;
(
  input  logic [31:0] op,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output alu_res_t    res
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [31:0] b, alu, sra;
  logic [4:0] sh;
  logic unused_ok;
  assign opc = op[6:0];
  assign f3 = op[14:12];
  assign b = opc == OPC_OP ? vk : imm;
  assign sh = b[4:0];
  assign sra = $signed(vj) >>> sh;
  assign unused_ok = &{1'b0, op[31], op[29:15], op[11:7]};
  always_comb begin
    alu = '0;
    case (f3)
      F3_ADD:  alu = (opc == OPC_OP && op[30]) ? vj - b : vj + b;
      F3_SLL:  alu = vj << sh;
      F3_SLT:  alu = {31'd0, $signed(vj) < $signed(b)};
      F3_SLTU: alu = {31'd0, vj < b};
      F3_XOR:  alu = vj ^ b;
      F3_SR:   alu = op[30] ? sra : vj >> sh;
      F3_OR:   alu = vj | b;
      F3_AND:  alu = vj & b;
      default: alu = '0;
    endcase
  end
  assign res.value = (opc == OPC_OP || opc == OPC_OP_IMM) ? alu :
                     opc == OPC_LUI ? imm :
                     opc == OPC_AUIPC ? pc + imm :
                     (opc == OPC_JAL || opc == OPC_JALR) ? pc + 32'd4 : '0;
`ifdef ALU_BRANCH_EN
  logic take;
  always_comb begin
    take = 1'b0;
    case (f3)
      F3_BEQ:  take = vj == vk;
      F3_BNE:  take = vj != vk;
      F3_BLT:  take = $signed(vj) < $signed(vk);
      F3_BGE:  take = $signed(vj) >= $signed(vk);
      F3_BLTU: take = vj < vk;
      F3_BGEU: take = vj >= vk;
      default: take = 1'b0;
    endcase
  end
  assign res.jump = opc == OPC_BRANCH ? take : (opc == OPC_JAL || opc == OPC_JALR);
  assign res.target = opc == OPC_JALR ? (vj + imm) & ~32'd1 :
                      (opc == OPC_BRANCH || opc == OPC_JAL) ? pc + imm : '0;
`else
  assign res.jump = 1'b0;
  assign res.target = '0;
`endif
endmodule

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: ALU execution unit with a result FIFO feeding the common data bus.
// Define ALU_BRANCH_EN to resolve branch/jump redirects; otherwise jump/target read 0.
module alu_cdb_unit
  import riscv_pkg::*;
#(
  parameter int ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 disp_valid_in,
  output logic                 disp_ready_out,
  input  logic [31:0]          disp_op_in,
  input  logic [31:0]          disp_vj_in,
  input  logic [31:0]          disp_vk_in,
  input  logic [31:0]          disp_pc_in,
  input  logic [31:0]          disp_imm_in,
  input  logic [ROB_IDX_W-1:0] disp_dest_in,
  output logic                 cdb_valid_out,
  input  logic                 cdb_grant_in,
  output logic [ROB_IDX_W-1:0] cdb_tag_out,
  output logic [31:0]          cdb_value_out,
  output logic                 cdb_jump_out,
  output logic [31:0]          cdb_target_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ROB_IDX_W-1:0] tag_q [FIFO_DEPTH];
  alu_res_t res_q [FIFO_DEPTH];
  alu_res_t res, head;
  logic push, pop;
  alu_core u_core (
    .op  (disp_op_in),
    .vj  (disp_vj_in),
    .vk  (disp_vk_in),
    .pc  (disp_pc_in),
    .imm (disp_imm_in),
    .res (res)
  );
  assign disp_ready_out = count < CW'(FIFO_DEPTH);
  assign cdb_valid_out = count != '0;
  assign push = rdy_in && !flush_in && disp_valid_in && disp_ready_out;
  assign pop = rdy_in && !flush_in && cdb_valid_out && cdb_grant_in;
  // Gate the head with valid so reset and empty both present an all-zero bus.
  assign head = cdb_valid_out ? res_q[rd_ptr] : '0;
  assign cdb_tag_out = cdb_valid_out ? tag_q[rd_ptr] : '0;
  assign cdb_value_out = head.value;
  assign cdb_jump_out = head.jump;
  assign cdb_target_out = head.target;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (rdy_in) begin
      wr_ptr <= flush_in ? '0 : wr_ptr + PW'(push);
      rd_ptr <= flush_in ? '0 : rd_ptr + PW'(pop);
      count <= flush_in ? '0 : count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      tag_q[wr_ptr] <= disp_dest_in;
      res_q[wr_ptr] <= res;
    end
  end
endmodule
